// File: rtl/vector_db_loader.sv
// Streams vector elements into a word-addressed SRAM and counts complete vectors.
// A bad s_last, an early stop or an address wrap raises a sticky error flag.
module vector_db_loader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              start_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        dim_size,
  input  logic [9:0]        max_vectors,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              stop_load,
  output logic              s_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [9:0]        vector_count,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [7:0]        r_dim;
  logic [9:0]        r_max;
  logic [ADDR_W-1:0] r_vecStart;
  logic [ADDR_W-1:0] r_wrPtr;
  logic [7:0]        r_idx;

  logic              w_inLoad;
  logic              w_fire;
  logic              w_lastIdx;
  logic              w_ptrWrap;
  logic [ADDR_W-1:0] w_ptrInc;
  logic [7:0]        w_idxNext;
  logic [ADDR_W-1:0] w_ptrNext;
  logic [ADDR_W-1:0] w_startNext;
  logic [9:0]        w_countNext;
  logic              w_errSet;

  assign w_inLoad  = (r_state == LOAD);
  assign w_fire    = s_valid && s_ready;
  assign w_lastIdx = (r_idx == (r_dim - 8'd1));
  assign w_ptrWrap = &r_wrPtr;
  assign w_ptrInc  = r_wrPtr + ADDR_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (start_load && dim_size != 8'd0) begin
          w_nextState = (max_vectors == 10'd0) ? FINISH : LOAD;
        end
      end
      LOAD: begin
        if (stop_load || vector_count == r_max) begin
          w_nextState = FINISH;
        end
      end
      FINISH:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
    if (clear) begin
      w_nextState = IDLE;
    end
  end

  // Beats stop being accepted once the capacity is reached, so none slip in before FINISH.
  always_comb begin
    s_ready = w_inLoad && (vector_count != r_max);
    busy    = w_inLoad;
    done    = (r_state == FINISH);
  end

  // The beat is resolved first; a same-cycle stop then discards whatever partial vector remains.
  always_comb begin
    w_idxNext   = r_idx;
    w_ptrNext   = r_wrPtr;
    w_startNext = r_vecStart;
    w_countNext = vector_count;
    w_errSet    = 1'b0;
    if (w_fire) begin
      if (w_lastIdx) begin
        w_countNext = vector_count + 10'd1;
        w_idxNext   = 8'd0;
        w_ptrNext   = w_ptrInc;
        w_startNext = w_ptrInc;
        w_errSet    = !s_last || w_ptrWrap;
      end else if (s_last) begin
        w_idxNext   = 8'd0;
        w_ptrNext   = r_vecStart;
        w_errSet    = 1'b1;
      end else begin
        w_idxNext   = r_idx + 8'd1;
        w_ptrNext   = w_ptrInc;
        w_errSet    = w_ptrWrap;
      end
    end
    if (w_inLoad && stop_load && w_idxNext != 8'd0) begin
      w_idxNext = 8'd0;
      w_ptrNext = w_startNext;
      w_errSet  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dim        <= '0;
      r_max        <= '0;
      r_vecStart   <= '0;
      r_wrPtr      <= '0;
      r_idx        <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      vector_count <= '0;
      error        <= 1'b0;
    end else if (clear) begin
      r_idx        <= '0;
      wr_en        <= 1'b0;
      vector_count <= '0;
      error        <= 1'b0;
    end else begin
      wr_en <= w_fire;
      if (w_fire) begin
        wr_addr <= r_wrPtr;
        wr_data <= s_data;
      end
      if (r_state == IDLE && start_load) begin
        r_dim        <= dim_size;
        r_max        <= max_vectors;
        r_vecStart   <= base_addr;
        r_wrPtr      <= base_addr;
        r_idx        <= '0;
        vector_count <= '0;
        error        <= (dim_size == 8'd0);
      end else if (w_inLoad) begin
        r_idx        <= w_idxNext;
        r_wrPtr      <= w_ptrNext;
        r_vecStart   <= w_startNext;
        vector_count <= w_countNext;
        if (w_errSet) begin
          error <= 1'b1;
        end
      end
    end
  end

endmodule
